// File: rtl/text_painter_if.sv
// Text-buffer write port bundle for text_painter.
interface text_painter_if #(
  parameter int unsigned AW = 12
);
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;

  modport master (output wr_en, wr_addr, wr_data);
  modport slave  (input  wr_en, wr_addr, wr_data);
endinterface

// File: rtl/text_painter.sv
// Character-cell text renderer: text buffer -> external font ROM -> per-pixel colour, 3-cycle pipeline.
// Optional blinking underline cursor compiled in with TEXT_PAINTER_CURSOR_EN.
module text_painter #(
  parameter int unsigned COLS         = 80,
  parameter int unsigned ROWS         = 30,
  parameter int unsigned FONT_WIDTH   = 8,
  parameter int unsigned FONT_HEIGHT  = 16,
  parameter logic [23:0] BG_COLOR     = 24'h000000,
  parameter int unsigned BLINK_FRAMES = 30,
  localparam int unsigned AW          = $clog2(COLS*ROWS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [9:0]            horzCoord,
  input  logic [9:0]            vertCoord,
  text_painter_if.slave         wr,
  input  logic [AW-1:0]         cursor_pos,
  output logic [10:0]           font_addr,
  input  logic [FONT_WIDTH-1:0] font_data,
  output logic                  pixel,
  output logic [23:0]           colors
);

  localparam int unsigned DEPTH = COLS*ROWS;
  localparam int unsigned FWB   = $clog2(FONT_WIDTH);
  localparam int unsigned FHB   = $clog2(FONT_HEIGHT);
  localparam int unsigned CW    = 10 - FWB;
  localparam int unsigned RW    = 10 - FHB;

  // stage 0: coordinate decode (combinational)
  logic [CW-1:0]  col_c;
  logic [RW-1:0]  row_c;
  logic [FWB-1:0] gx_c;
  logic [FHB-1:0] gy_c;
  logic           in_area_c;
  logic [31:0]    lin_c;
  logic [AW-1:0]  rd_addr_c;

  assign col_c     = horzCoord[9:FWB];
  assign gx_c      = horzCoord[FWB-1:0];
  assign row_c     = vertCoord[9:FHB];
  assign gy_c      = vertCoord[FHB-1:0];
  assign in_area_c = (32'(col_c) < COLS) && (32'(row_c) < ROWS);
  assign lin_c     = 32'(row_c) * COLS + 32'(col_c);
  // Off-screen coordinates read a harmless in-range cell; in_area masks the result.
  assign rd_addr_c = in_area_c ? AW'(lin_c) : '0;

  // text buffer: read-first, contents survive reset
  logic [31:0] mem [DEPTH];
  logic [31:0] cell_q;

  always_ff @(posedge clk) begin
    if (rst_n && wr.wr_en && (32'(wr.wr_addr) < DEPTH)) begin
      mem[wr.wr_addr] <= wr.wr_data;
    end
    cell_q <= mem[rd_addr_c];
  end

  // pipeline registers
  logic [FWB-1:0] gx1, gx2, gx3;
  logic [FHB-1:0] gy1;
  logic           in1, in2, in3;
  logic [23:0]    color2, color3;
  logic [31:0]    fa_c;

  assign fa_c = 32'(cell_q[6:0]) * FONT_HEIGHT + 32'(gy1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gx1       <= '0;
      gy1       <= '0;
      in1       <= 1'b0;
      gx2       <= '0;
      in2       <= 1'b0;
      color2    <= '0;
      font_addr <= '0;
      gx3       <= '0;
      in3       <= 1'b0;
      color3    <= '0;
    end else begin
      gx1       <= gx_c;
      gy1       <= gy_c;
      in1       <= in_area_c;
      gx2       <= gx1;
      in2       <= in1;
      color2    <= cell_q[31:8];
      font_addr <= 11'(fa_c);
      gx3       <= gx2;
      in3       <= in2;
      color3    <= color2;
    end
  end

  logic cursor_c;

`ifdef TEXT_PAINTER_CURSOR_EN
  localparam int unsigned BCW = $clog2(BLINK_FRAMES + 1);

  logic [BCW-1:0] blink_cnt;
  logic           blink_hidden;
  logic [AW-1:0]  addr1;
  logic           cur2, cur3;
  logic           frame_start_c;
  logic           hit_c;

  assign frame_start_c = (horzCoord == '0) && (vertCoord == '0);
  // bottom two glyph rows of the cursor cell form the underline
  assign hit_c = !blink_hidden && in1 && (addr1 == cursor_pos) &&
                 (32'(gy1) >= (FONT_HEIGHT - 2));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      blink_cnt    <= '0;
      blink_hidden <= 1'b0;
      addr1        <= '0;
      cur2         <= 1'b0;
      cur3         <= 1'b0;
    end else begin
      if (frame_start_c) begin
        if (blink_cnt == BCW'(BLINK_FRAMES - 1)) begin
          blink_cnt    <= '0;
          blink_hidden <= !blink_hidden;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end
      addr1 <= rd_addr_c;
      cur2  <= hit_c;
      cur3  <= cur2;
    end
  end

  assign cursor_c = cur3;
`else
  logic unused_cursor_c;
  assign unused_cursor_c = ^cursor_pos;
  assign cursor_c        = 1'b0;
`endif

  // stage 3: glyph bit select, MSB is leftmost pixel
  logic [FWB-1:0] bit_idx_c;
  logic           glyph_c;
  logic           fg_c;
  logic           unused_cell_c;

  assign bit_idx_c     = FWB'(FONT_WIDTH - 1) - gx3;
  assign glyph_c       = font_data[bit_idx_c];
  assign fg_c          = (in3 && glyph_c) || cursor_c;
  assign unused_cell_c = cell_q[7];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pixel  <= 1'b0;
      colors <= BG_COLOR;
    end else begin
      pixel  <= fg_c;
      colors <= fg_c ? color3 : BG_COLOR;
    end
  end

endmodule

// File: tb/tb_text_painter.sv
// Scoreboard bench for text_painter: directed coordinates, bench-side font ROM and text model.
module tb_text_painter;

  localparam int unsigned AW = 12;
  localparam logic [23:0] BG = 24'h123456;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  horzCoord, vertCoord;
  logic [AW-1:0] cursor_pos;
  logic [10:0] font_addr;
  logic [7:0]  font_data;
  logic        pixel;
  logic [23:0] colors;

  text_painter_if #(.AW(AW)) wif ();

  text_painter #(
    .COLS(80), .ROWS(30), .FONT_WIDTH(8), .FONT_HEIGHT(16),
    .BG_COLOR(BG), .BLINK_FRAMES(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .horzCoord(horzCoord), .vertCoord(vertCoord),
    .wr(wif.slave), .cursor_pos(cursor_pos), .font_addr(font_addr),
    .font_data(font_data), .pixel(pixel), .colors(colors)
  );

  always #5 clk = ~clk;

  logic [7:0]  rom [2048];
  logic [31:0] tmodel [2400];

  always @(posedge clk) font_data <= rom[font_addr];

  typedef struct packed { logic pix; logic [23:0] col; } out_t;
  typedef struct packed { logic care; logic [10:0] fa; } fa_t;
  out_t out_q[$];
  fa_t  fa_q[$];

  int checks = 0;
  int failures = 0;
  logic issue = 1'b0;
  logic [3:0] iss_sr = '0;

  always @(posedge clk) iss_sr <= {iss_sr[2:0], issue};

  // monitor: font_addr one edge after stage 1, pixel/colors three edges after
  always @(negedge clk) begin
    if (iss_sr[1]) begin
      if (fa_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL fa_queue: underflow");
      end else begin
        fa_t e;
        e = fa_q.pop_front();
        if (e.care) begin
          checks++;
          if (font_addr !== e.fa) begin
            failures++;
            $display("FAIL font_addr: got %h want %h", font_addr, e.fa);
          end
        end
      end
    end
    if (iss_sr[3]) begin
      if (out_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL out_queue: underflow");
      end else begin
        out_t o;
        o = out_q.pop_front();
        checks++;
        if (pixel !== o.pix || colors !== o.col) begin
          failures++;
          $display("FAIL pixel_out @%0t: got pixel=%b colors=%h want pixel=%b colors=%h",
                   $time, pixel, colors, o.pix, o.col);
        end
      end
    end
  end

  function automatic void model(input int x, input int y, output logic p,
                                output logic [23:0] c, output logic care,
                                output logic [10:0] fa);
    int col, row, gy, gx;
    logic [31:0] w;
    logic [7:0]  r;
    col = x / 8; row = y / 16; gy = y % 16; gx = x % 8;
    p = 1'b0; c = BG; care = 1'b0; fa = '0;
    if (col < 80 && row < 30) begin
      w    = tmodel[row*80 + col];
      fa   = 11'(int'(w[6:0]) * 16 + gy);
      care = 1'b1;
      r    = rom[fa];
      if (r[7-gx]) begin
        p = 1'b1;
        c = w[31:8];
      end
    end
  endfunction

  task automatic drive(input int x, input int y, input bit iss, input bit flush,
                       input bit rst, input bit we, input int wa, input logic [31:0] wd,
                       input bit ovr);
    logic p, care;
    logic [23:0] c;
    logic [10:0] fa;
    @(negedge clk);
    rst_n       = !rst;
    horzCoord   = 10'(x);
    vertCoord   = 10'(y);
    wif.wr_en   = we;
    wif.wr_addr = AW'(wa);
    wif.wr_data = wd;
    issue       = iss;
    if (iss) begin
      model(x, y, p, c, care, fa);
      if (flush) begin p = 1'b0; c = BG; care = 1'b0; end
      if (ovr) begin p = 1'b1; c = 24'h00FF00; end
      out_q.push_back('{pix: p, col: c});
      fa_q.push_back('{care: care, fa: fa});
    end
    if (we && !rst && wa < 2400) tmodel[wa] = wd;
  endtask

  task automatic pt(input int x, input int y);
    drive(x, y, 1, 0, 0, 0, 0, 32'h0, 0);
  endtask
  task automatic ptf(input int x, input int y);
    drive(x, y, 1, 1, 0, 0, 0, 32'h0, 0);
  endtask
  task automatic idle(input bit rst);
    drive(1023, 1023, 0, 0, rst, 0, 0, 32'h0, 0);
  endtask
  task automatic wr(input int a, input logic [31:0] d);
    drive(1023, 1023, 0, 0, 0, 1, a, d, 0);
  endtask

  initial begin
    bit vis;
    for (int i = 0; i < 2048; i++) rom[i] = 8'h00;
    for (int i = 0; i < 2400; i++) tmodel[i] = 32'h0;
    rom[11'h410] = 8'h80; rom[11'h411] = 8'h3C; rom[11'h41F] = 8'h01;
    rom[11'h420] = 8'h81; rom[11'h43F] = 8'hFF;
    rst_n = 1'b0; horzCoord = 10'd1023; vertCoord = 10'd1023;
    wif.wr_en = 1'b0; wif.wr_addr = '0; wif.wr_data = '0;
    cursor_pos = 12'hFFF;

    repeat (3) idle(1);
    @(posedge clk); #1;
    checks += 3;
    if (pixel !== 1'b0) begin failures++; $display("FAIL reset_pixel: got %b want 0", pixel); end
    if (colors !== BG) begin failures++; $display("FAIL reset_colors: got %h want %h", colors, BG); end
    if (font_addr !== 11'h0) begin failures++; $display("FAIL reset_font_addr: got %h want 000", font_addr); end

    wr(0,    {24'hFF0000, 8'h41});
    wr(1,    {24'h00FF00, 8'h42});
    wr(5,    {24'h0000FF, 8'h42});
    wr(79,   {24'hFFFFFF, 8'hC3});
    wr(2399, {24'hABCDEF, 8'h41});

    pt(0, 0);        // A row0 MSB -> FF0000
    pt(1, 0);        // bit6 clear -> BG
    pt(2, 1);        // 0x3C bit5 -> FF0000
    pt(8, 0);        // B row0 0x81 MSB -> 00FF00
    pt(15, 0);       // LSB -> 00FF00
    pt(12, 0);       // bit3 clear -> BG
    pt(632, 15);     // C (bit7 of code ignored) row15 0xFF -> FFFFFF
    pt(639, 479);    // last cell, 0x01 LSB -> ABCDEF
    pt(640, 0);      // right of text area -> BG
    pt(0, 480);      // below text area -> BG
    pt(1023, 1023);

    // same-cycle write/read of cell 5: old 'B' first, then new 'C'
    drive(40, 0, 1, 0, 0, 1, 5, {24'h00FFFF, 8'h43}, 0);
    pt(40, 0);

    // mid-stream reset: last three in-flight items and the reset-cycle item are flushed
    pt(0, 0);
    ptf(8, 0);
    ptf(15, 0);
    ptf(0, 0);
    drive(0, 0, 1, 1, 1, 1, 0, {24'h111111, 8'h42}, 0);
    pt(0, 0);
    pt(8, 0);
    pt(2, 1);
    repeat (5) idle(0);

    // blinking cursor on a blank cell, two frames per half-period
    repeat (2) idle(1);
    cursor_pos = 12'd0;
    wr(0, {24'h00FF00, 8'h00});
    for (int f = 0; f < 5; f++) begin
      if (f > 0) pt(0, 0);
`ifdef TEXT_PAINTER_CURSOR_EN
      vis = ((f / 2) % 2) == 0;
`else
      vis = 1'b0;
`endif
      drive(0, 15, 1, 0, 0, 0, 0, 32'h0, vis);
      idle(0);
    end
    repeat (6) idle(0);

    checks++;
    if (out_q.size() != 0 || fa_q.size() != 0) begin
      failures++;
      $display("FAIL drain: out_q=%0d fa_q=%0d want 0", out_q.size(), fa_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/text_painter.md
TEXT_PAINTER -- requirements
Module: text_painter

Interface
REQ-001 Parameter COLS, default 80: text columns.
REQ-002 Parameter ROWS, default 30: text rows.
REQ-003 Parameter FONT_WIDTH, default 8: glyph width, pixels; power of two.
REQ-004 Parameter FONT_HEIGHT, default 16: glyph height, pixels; power of two.
REQ-005 Parameter BG_COLOR, default 24'h000000: colour when pixel is 0.
REQ-006 Parameter BLINK_FRAMES, default 30: frames per cursor blink half-period.
REQ-007 Derived constant AW = $clog2(COLS*ROWS): width of text-cell addresses.
REQ-008 Port clk, input, 1: single clock; all logic on rising edge.
REQ-009 Port rst_n, input, 1: reset, synchronous, active-low.
REQ-010 Port horzCoord, input, 10: current pixel column.
REQ-011 Port vertCoord, input, 10: current pixel row.
REQ-012 Port wr_en, input, 1: text-buffer write strobe.
REQ-013 Port wr_addr, input, AW: cell index, row*COLS+col.
REQ-014 Port wr_data, input, 32: [31:8] foreground colour, [6:0] character code, [7] ignored.
REQ-015 Port cursor_pos, input, AW: cursor cell index.
REQ-016 Port font_addr, output, 11: glyph-row address to external font ROM.
REQ-017 Port font_data, input, FONT_WIDTH: ROM data, valid one cycle after font_addr.
REQ-018 Port pixel, output, 1: foreground pixel flag.
REQ-019 Port colors, output, 24: RGB colour for current pixel.

Function
REQ-020 Text buffer: internal COLS*ROWS x 32 memory; write on wr_en when wr_addr < COLS*ROWS; out-of-range writes dropped.
REQ-021 Read and write to the same cell in the same cycle: read returns the old contents (read-first).
REQ-022 Stage 1 registers col=horzCoord/FONT_WIDTH, row=vertCoord/FONT_HEIGHT, gy=vertCoord%FONT_HEIGHT, gx=horzCoord%FONT_WIDTH, in_area=(col<COLS && row<ROWS), and reads cell row*COLS+col.
REQ-023 Stage 2 registers font_addr = code*FONT_HEIGHT + gy, truncated to 11 bits; gx, in_area and colour are delayed alongside.
REQ-024 Stage 3 selects bit font_data[FONT_WIDTH-1-gx]; the MSB is the leftmost glyph pixel.
REQ-025 Latency: pixel/colors for a coordinate sampled at rising edge n are valid after edge n+3, one result per cycle, no stalls.
REQ-026 Output rule: pixel=1 and colors=cell colour when in_area and the glyph bit is 1; otherwise pixel=0 and colors=BG_COLOR.
REQ-027 Coordinates outside the text area never read stale cell data into the output; the output follows REQ-026 with in_area=0.

Reset
REQ-028 While rst_n=0 at a rising edge: pixel=0, colors=BG_COLOR, font_addr=0, all pipeline valid/in_area bits=0, blink counter=0, blink phase=visible.
REQ-029 Text-buffer contents are not cleared by reset; writes while rst_n=0 are dropped.
REQ-030 Reset asserted mid-frame flushes all three stages; the first valid output appears 3 edges after rst_n deasserts.

Configuration
REQ-031 Macro TEXT_PAINTER_CURSOR_EN compiles in the blinking cursor.
REQ-032 With the macro: a frame counter increments at each sampled horzCoord=0, vertCoord=0; on reaching BLINK_FRAMES-1 it wraps to 0 and toggles the blink phase.
REQ-033 With the macro: when blink phase=visible, the cell equals cursor_pos, and gy >= FONT_HEIGHT-2, the output is forced to pixel=1, colors=cell colour, with the same 3-cycle latency.
REQ-034 Without the macro: no counter and no cursor logic; cursor_pos is ignored and the output follows REQ-026 only.

Verification
REQ-035 Write cell 0 = {24'hFF0000, 8'h41}, ROM row for 'A' gy=0 = 8'h80; present (0,0) -> after edge n+3 pixel=1, colors=FF0000; font_addr = 0x410 at edge n+2.
REQ-036 Same setup, present (1,0) -> pixel=0, colors=BG_COLOR.
REQ-037 Present (640,0) with COLS=80 -> pixel=0, colors=BG_COLOR regardless of font_data.
REQ-038 Write and read cell 5 in the same cycle -> old code appears on font_addr; the next access returns the new code.
REQ-039 Assert rst_n=0 for 1 cycle mid-stream -> pixel=0, colors=BG_COLOR for 3 edges after deassertion, then correct data.
REQ-040 With TEXT_PAINTER_CURSOR_EN, cursor_pos=0, BLINK_FRAMES=2, blank cell: at (0,15) pixel=1 in frames 0-1 and pixel=0 in frames 2-3.
